// File: rtl/fetch_queue_pkg.sv
// Shared constants and helpers for the instruction fetch queue.
package fetch_queue_pkg;

    localparam int LINE_WORDS_DEFAULT = 4;
    localparam int WORD_BYTES         = 4;

    // Bits needed to index a word inside a cache line.
    function automatic int off_width(input int line_words);
        return $clog2(line_words);
    endfunction

endpackage

// File: rtl/fetch_queue_ram.sv
// Line storage: DEPTH entries of {line base PC, line data}, one write port,
// asynchronous read, no reset on contents.
module fetch_queue_ram #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 160
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [WIDTH-1:0]         wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [WIDTH-1:0]         rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/fetch_queue.sv
// Instruction fetch queue: pulls whole cache lines from the icache and hands
// them to dispatch one word at a time. Handshakes: a request is icache_rd_en
// held high with a stable icache_pc_in; it completes on the cycle
// icache_dout_valid is high, or is cancelled by a one-cycle icache_abort.
// Dispatch consumes the head word on any cycle dispatch_rd_en is high while
// dispatch_empty is low.
module fetch_queue
    import fetch_queue_pkg::*;
#(
    parameter int          DEPTH      = 4,
    parameter int          LINE_WORDS = LINE_WORDS_DEFAULT,
    parameter logic [31:0] RESET_PC   = 32'h0000_0000
) (
    input  logic                       clk,
    input  logic                       rst,
    output logic [31:0]                icache_pc_in,
    output logic                       icache_rd_en,
    output logic                       icache_abort,
    input  logic [32*LINE_WORDS-1:0]   icache_dout,
    input  logic                       icache_dout_valid,
    output logic [31:0]                dispatch_pc_out,
    output logic [31:0]                dispatch_inst,
    output logic                       dispatch_empty,
    input  logic                       dispatch_rd_en,
    input  logic [31:0]                dispatch_jump_branch_address,
    input  logic                       dispatch_jump_branch_valid,
    output logic [$clog2(DEPTH):0]     level
);

    localparam int          AW         = $clog2(DEPTH);
    localparam int          OW         = off_width(LINE_WORDS);
    localparam int          LINE_BITS  = 32 * LINE_WORDS;
    localparam int          LINE_BYTES = WORD_BYTES * LINE_WORDS;
    localparam int          ENTRY_BITS = LINE_BITS + 32;
    localparam logic [31:0] LINE_MASK  = ~(32'(LINE_BYTES) - 32'd1);

    logic [31:0]         fetch_pc;
    logic [AW-1:0]       wr_ptr;
    logic [AW-1:0]       rd_ptr;
    logic [AW:0]         level_q;
    logic [OW-1:0]       off;

    logic                empty_q;
    logic                consume;
    logic                pop;
    logic                push;
    logic                rd_en_int;
    logic [ENTRY_BITS-1:0] head;
    logic [LINE_BITS-1:0]  head_line;
    logic [31:0]           head_pc;

    assign empty_q   = (level_q == '0);
    // A redirect wins over both ends of the queue in the same cycle.
    assign consume   = dispatch_rd_en && !empty_q && !dispatch_jump_branch_valid;
    assign pop       = consume && (off == OW'(LINE_WORDS - 1));
    assign rd_en_int = !rst && ((level_q != (AW+1)'(DEPTH)) || pop);
    assign push      = rd_en_int && icache_dout_valid && !dispatch_jump_branch_valid;

    assign icache_rd_en   = rd_en_int;
    assign icache_abort   = rd_en_int && dispatch_jump_branch_valid;
    assign icache_pc_in   = rst ? RESET_PC : fetch_pc;
    assign dispatch_empty = rst || empty_q;
    assign level          = rst ? '0 : level_q;

    fetch_queue_ram #(
        .DEPTH (DEPTH),
        .WIDTH (ENTRY_BITS)
    ) u_ram (
        .clk   (clk),
        .we    (push),
        .waddr (wr_ptr),
        .wdata ({fetch_pc, icache_dout}),
        .raddr (rd_ptr),
        .rdata (head)
    );

    assign head_line       = head[LINE_BITS-1:0];
    assign head_pc         = head[LINE_BITS +: 32];
    assign dispatch_inst   = head_line[32*int'(off) +: 32];
    assign dispatch_pc_out = head_pc + {{(30-OW){1'b0}}, off, 2'b00};

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc <= RESET_PC;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            level_q  <= '0;
            off      <= '0;
        end else if (dispatch_jump_branch_valid) begin
            // The first line fetched after a redirect starts at the target word.
            fetch_pc <= dispatch_jump_branch_address & LINE_MASK;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            level_q  <= '0;
            off      <= dispatch_jump_branch_address[OW+1:2];
        end else begin
            if (push) begin
                wr_ptr   <= wr_ptr + 1'b1;
                fetch_pc <= fetch_pc + 32'(LINE_BYTES);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (consume) begin
                off <= pop ? '0 : off + 1'b1;
            end
            if (push && !pop) begin
                level_q <= level_q + 1'b1;
            end else if (pop && !push) begin
                level_q <= level_q - 1'b1;
            end
        end
    end

endmodule
